mem_port_arbiter: RTL and testbench

Two-requester arbiter that shares the single 256-bit-line Data_Memory port between the data cache (port 0) and the instruction cache (port 1). It sits between the CPU-side caches and Data_Memory, reusing the memory's enable/write/ack handshake on both sides. Each request is registered, forwarded to memory, and held until ack. The ack and read data are then returned to the winning requester. Round-robin fairness, a per-access watchdog and saturating grant counters are included.

---
 rtl/mem_port_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing the single Data_Memory line port between the data
// cache (port 0) and the instruction cache (port 1), with a per-access watchdog.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned LINE_W  = 256,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req0_enable_i,
  input  logic              req0_write_i,
  input  logic [ADDR_W-1:0] req0_addr_i,
  input  logic [LINE_W-1:0] req0_data_i,
  output logic              req0_ack_o,
  output logic [LINE_W-1:0] req0_data_o,
  output logic              req0_err_o,
  input  logic              req1_enable_i,
  input  logic              req1_write_i,
  input  logic [ADDR_W-1:0] req1_addr_i,
  input  logic [LINE_W-1:0] req1_data_i,
  output logic              req1_ack_o,
  output logic [LINE_W-1:0] req1_data_o,
  output logic              req1_err_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic              mem_ack_i,
  input  logic [LINE_W-1:0] mem_data_i,
  output logic [15:0]       grant0_cnt_o,
  output logic [15:0]       grant1_cnt_o,
  output logic              timeout_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BUSY    = 2'd1,
    S_RELEASE = 2'd2
  } state_e;

  localparam logic [7:0] TIMEOUT_L = 8'(TIMEOUT);

  state_e            r_state,      w_state_nxt;
  logic              r_last,       w_last_nxt;   // port granted most recently
  logic              r_owner,      w_owner_nxt;
  logic [7:0]        r_wd_cnt,     w_wd_cnt_nxt;
  logic              r_mem_enable, w_mem_enable_nxt;
  logic              r_mem_write,  w_mem_write_nxt;
  logic [ADDR_W-1:0] r_mem_addr,   w_mem_addr_nxt;
  logic [LINE_W-1:0] r_mem_data,   w_mem_data_nxt;
  logic              r_ack0,       w_ack0_nxt;
  logic              r_ack1,       w_ack1_nxt;
  logic              r_err0,       w_err0_nxt;
  logic              r_err1,       w_err1_nxt;
  logic [LINE_W-1:0] r_rdata0,     w_rdata0_nxt;
  logic [LINE_W-1:0] r_rdata1,     w_rdata1_nxt;
  logic [15:0]       r_cnt0,       w_cnt0_nxt;
  logic [15:0]       r_cnt1,       w_cnt1_nxt;
  logic              r_timeout,    w_timeout_nxt;

  logic       w_any_req;
  logic       w_both_req;
  logic       w_win;
  logic [7:0] w_wd_inc;
  logic       w_wd_expired;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign w_any_req    = req0_enable_i | req1_enable_i;
  assign w_both_req   = req0_enable_i & req1_enable_i;
  // On contention the port that did not win last time goes first.
  assign w_win        = w_both_req ? ~r_last : req1_enable_i;
  assign w_wd_inc     = r_wd_cnt + 8'd1;
  assign w_wd_expired = (w_wd_inc == TIMEOUT_L);

  // NOTE: every next-state signal is given its hold value first, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt      = r_state;
    w_last_nxt       = r_last;
    w_owner_nxt      = r_owner;
    w_wd_cnt_nxt     = r_wd_cnt;
    w_mem_enable_nxt = r_mem_enable;
    w_mem_write_nxt  = r_mem_write;
    w_mem_addr_nxt   = r_mem_addr;
    w_mem_data_nxt   = r_mem_data;
    w_ack0_nxt       = 1'b0;
    w_ack1_nxt       = 1'b0;
    w_err0_nxt       = 1'b0;
    w_err1_nxt       = 1'b0;
    w_rdata0_nxt     = r_rdata0;
    w_rdata1_nxt     = r_rdata1;
    w_cnt0_nxt       = r_cnt0;
    w_cnt1_nxt       = r_cnt1;
    w_timeout_nxt    = r_timeout;

    unique case (r_state)
      S_IDLE: begin
        if (w_any_req) begin
          w_owner_nxt      = w_win;
          w_last_nxt       = w_win;
          w_wd_cnt_nxt     = 8'd0;
          w_mem_enable_nxt = 1'b1;
          w_mem_write_nxt  = w_win ? req1_write_i : req0_write_i;
          w_mem_addr_nxt   = w_win ? req1_addr_i  : req0_addr_i;
          w_mem_data_nxt   = w_win ? req1_data_i  : req0_data_i;
          if (w_win) w_cnt1_nxt = sat_inc(r_cnt1);
          else       w_cnt0_nxt = sat_inc(r_cnt0);
          w_state_nxt      = S_BUSY;
        end
      end

      S_BUSY: begin
        if (mem_ack_i) begin
          w_mem_enable_nxt = 1'b0;
          w_mem_write_nxt  = 1'b0;
          w_ack0_nxt       = ~r_owner;
          w_ack1_nxt       = r_owner;
          if (!r_mem_write) begin
            if (r_owner) w_rdata1_nxt = mem_data_i;
            else         w_rdata0_nxt = mem_data_i;
          end
          w_state_nxt      = S_RELEASE;
        end else if (w_wd_expired) begin
          w_mem_enable_nxt = 1'b0;
          w_mem_write_nxt  = 1'b0;
          w_ack0_nxt       = ~r_owner;
          w_ack1_nxt       = r_owner;
          w_err0_nxt       = ~r_owner;
          w_err1_nxt       = r_owner;
          w_timeout_nxt    = 1'b1;
          w_state_nxt      = S_RELEASE;
        end else begin
          w_wd_cnt_nxt     = w_wd_inc;
        end
      end

      // Ack is visible for this one cycle while the requester drops its enable.
      S_RELEASE: w_state_nxt = S_IDLE;

      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: state is updated only with non-blocking assignments so every register
  // samples the values computed before this edge, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_last       <= 1'b1;
      r_owner      <= 1'b0;
      r_wd_cnt     <= 8'd0;
      r_mem_enable <= 1'b0;
      r_mem_write  <= 1'b0;
      // NOTE: the wide line and address registers are cleared as well, because
      // their reset value is architecturally visible on the outputs.
      r_mem_addr   <= '0;
      r_mem_data   <= '0;
      r_ack0       <= 1'b0;
      r_ack1       <= 1'b0;
      r_err0       <= 1'b0;
      r_err1       <= 1'b0;
      r_rdata0     <= '0;
      r_rdata1     <= '0;
      r_cnt0       <= 16'd0;
      r_cnt1       <= 16'd0;
      r_timeout    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_last       <= w_last_nxt;
      r_owner      <= w_owner_nxt;
      r_wd_cnt     <= w_wd_cnt_nxt;
      r_mem_enable <= w_mem_enable_nxt;
      r_mem_write  <= w_mem_write_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_mem_data   <= w_mem_data_nxt;
      r_ack0       <= w_ack0_nxt;
      r_ack1       <= w_ack1_nxt;
      r_err0       <= w_err0_nxt;
      r_err1       <= w_err1_nxt;
      r_rdata0     <= w_rdata0_nxt;
      r_rdata1     <= w_rdata1_nxt;
      r_cnt0       <= w_cnt0_nxt;
      r_cnt1       <= w_cnt1_nxt;
      r_timeout    <= w_timeout_nxt;
    end
  end

  assign req0_ack_o   = r_ack0;
  assign req1_ack_o   = r_ack1;
  assign req0_err_o   = r_err0;
  assign req1_err_o   = r_err1;
  assign req0_data_o  = r_rdata0;
  assign req1_data_o  = r_rdata1;
  assign mem_enable_o = r_mem_enable;
  assign mem_write_o  = r_mem_write;
  assign mem_addr_o   = r_mem_addr;
  assign mem_data_o   = r_mem_data;
  assign grant0_cnt_o = r_cnt0;
  assign grant1_cnt_o = r_cnt1;
  assign timeout_o    = r_timeout;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: transaction-level reference model,
// scripted requesters, a latency-controlled memory, directed and random traffic.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int LW = 256;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          req0_enable_i, req1_enable_i, req0_write_i, req1_write_i;
  logic [AW-1:0] req0_addr_i, req1_addr_i;
  logic [LW-1:0] req0_data_i, req1_data_i;
  logic          req0_ack_o, req1_ack_o, req0_err_o, req1_err_o;
  logic [LW-1:0] req0_data_o, req1_data_o;
  logic          mem_enable_o, mem_write_o;
  logic [AW-1:0] mem_addr_o;
  logic [LW-1:0] mem_data_o;
  logic          mem_ack_i;
  logic [LW-1:0] mem_data_i;
  logic [15:0]   grant0_cnt_o, grant1_cnt_o;
  logic          timeout_o;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .LINE_W(LW), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req0_enable_i(req0_enable_i), .req0_write_i(req0_write_i),
    .req0_addr_i(req0_addr_i), .req0_data_i(req0_data_i),
    .req0_ack_o(req0_ack_o), .req0_data_o(req0_data_o), .req0_err_o(req0_err_o),
    .req1_enable_i(req1_enable_i), .req1_write_i(req1_write_i),
    .req1_addr_i(req1_addr_i), .req1_data_i(req1_data_i),
    .req1_ack_o(req1_ack_o), .req1_data_o(req1_data_o), .req1_err_o(req1_err_o),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i),
    .grant0_cnt_o(grant0_cnt_o), .grant1_cnt_o(grant1_cnt_o), .timeout_o(timeout_o)
  );

  // ---------------- requester scripts ----------------
  typedef struct {
    bit          we;
    bit [31:0]   addr;
    bit [255:0]  data;
    int          gap;   // idle cycles before raising enable
  } req_t;

  req_t       q [2][$];
  bit         drv_en   [2];
  bit         drv_we   [2];
  bit [31:0]  drv_addr [2];
  bit [255:0] drv_data [2];
  int         gap_cnt  [2];

  assign req0_enable_i = drv_en[0];
  assign req1_enable_i = drv_en[1];
  assign req0_write_i  = drv_we[0];
  assign req1_write_i  = drv_we[1];
  assign req0_addr_i   = drv_addr[0];
  assign req1_addr_i   = drv_addr[1];
  assign req0_data_i   = drv_data[0];
  assign req1_data_i   = drv_data[1];

  // Backing store of the simulated Data_Memory.
  bit [255:0] bmem [bit [31:0]];

  // ---------------- reference model (access-level view) ----------------
  typedef enum {M_IDLE, M_ACTIVE, M_ACK} mphase_e;
  mphase_e    m_phase;
  int         m_owner, m_busy, m_lat, m_last;
  bit         m_we, m_timeout;
  bit [31:0]  m_addr;
  bit [255:0] m_data;
  bit         m_ack [2];
  bit         m_err [2];
  bit [255:0] m_rdata [2];
  int         m_cnt [2];

  int lat_mode;   // -1 random, 0 never ack, N ack after N enabled cycles
  bit noise_en;   // spurious mem_ack_i while no access is in flight

  // ---------------- tallies of DUT behaviour ----------------
  int         t_ack [2];
  int         t_err [2];
  int         t_en_cycles, t_wr_cycles;
  bit         prev_en;
  bit [31:0]  t_grant_addr [$];
  int         t_ack_order [$];

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic bit [255:0] rand_line();
    bit [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic model_reset();
    m_phase   = M_IDLE;
    m_owner   = 0;
    m_busy    = 0;
    m_lat     = 0;
    m_last    = 1;
    m_we      = 0;
    m_timeout = 0;
    m_addr    = '0;
    m_data    = '0;
    for (int p = 0; p < 2; p++) begin
      m_ack[p] = 0; m_err[p] = 0; m_rdata[p] = '0; m_cnt[p] = 0;
    end
  endtask

  task automatic model_step(input bit mack, input bit [255:0] mdata);
    int w;
    case (m_phase)
      M_ACK: begin
        m_ack[0] = 0; m_ack[1] = 0; m_err[0] = 0; m_err[1] = 0;
        m_phase = M_IDLE;
      end
      M_ACTIVE: begin
        if (mack) begin
          m_ack[m_owner] = 1;
          if (m_we) bmem[m_addr] = m_data;
          else      m_rdata[m_owner] = mdata;
          m_phase = M_ACK;
        end else if (m_busy == TO) begin
          m_ack[m_owner] = 1;
          m_err[m_owner] = 1;
          m_timeout = 1;
          m_phase = M_ACK;
        end else begin
          m_busy++;
        end
      end
      default: begin
        w = -1;
        if (drv_en[0] && drv_en[1]) w = 1 - m_last;
        else if (drv_en[0])         w = 0;
        else if (drv_en[1])         w = 1;
        if (w >= 0) begin
          m_owner = w;
          m_last  = w;
          m_we    = drv_we[w];
          m_addr  = drv_addr[w];
          m_data  = drv_data[w];
          m_busy  = 1;
          m_cnt[w] = (m_cnt[w] == 65535) ? 65535 : m_cnt[w] + 1;
          if (lat_mode < 0) m_lat = ($urandom_range(15) == 0) ? 0 : int'($urandom_range(8, 1));
          else              m_lat = lat_mode;
          m_phase = M_ACTIVE;
        end
      end
    endcase
  endtask

  // One clock: compare outputs against the model, then drive the next inputs
  // and advance the model across the coming rising edge.
  task automatic cycle(input bit do_rst);
    bit         mack;
    bit [255:0] mdata;
    @(negedge clk);

    check("mem_enable", mem_enable_o, m_phase == M_ACTIVE);
    check("mem_write",  mem_write_o,  (m_phase == M_ACTIVE) && m_we);
    check("mem_addr",   mem_addr_o,   m_addr);
    check("mem_data",   mem_data_o,   m_data);
    check("req0_ack",   req0_ack_o,   m_ack[0]);
    check("req1_ack",   req1_ack_o,   m_ack[1]);
    check("req0_err",   req0_err_o,   m_err[0]);
    check("req1_err",   req1_err_o,   m_err[1]);
    check("req0_data",  req0_data_o,  m_rdata[0]);
    check("req1_data",  req1_data_o,  m_rdata[1]);
    check("grant0_cnt", grant0_cnt_o, m_cnt[0]);
    check("grant1_cnt", grant1_cnt_o, m_cnt[1]);
    check("timeout",    timeout_o,    m_timeout);

    t_ack[0] += int'(req0_ack_o);
    t_ack[1] += int'(req1_ack_o);
    t_err[0] += int'(req0_err_o);
    t_err[1] += int'(req1_err_o);
    t_en_cycles += int'(mem_enable_o);
    t_wr_cycles += int'(mem_write_o);
    if (mem_enable_o && !prev_en) t_grant_addr.push_back(mem_addr_o);
    prev_en = mem_enable_o;
    if (req0_ack_o) t_ack_order.push_back(0);
    if (req1_ack_o) t_ack_order.push_back(1);

    for (int p = 0; p < 2; p++) begin
      if (do_rst) begin
        drv_en[p]  = 0;
        gap_cnt[p] = 0;
      end else if (m_ack[p]) begin
        drv_en[p] = 0;
      end else if (!drv_en[p] && q[p].size() > 0) begin
        if (gap_cnt[p] < q[p][0].gap) begin
          gap_cnt[p]++;
        end else begin
          req_t r;
          r = q[p].pop_front();
          drv_en[p]   = 1;
          drv_we[p]   = r.we;
          drv_addr[p] = r.addr;
          drv_data[p] = r.data;
          gap_cnt[p]  = 0;
        end
      end
      if (!drv_en[p]) begin
        drv_we[p]   = bit'($urandom_range(1));
        drv_addr[p] = $urandom;
        drv_data[p] = rand_line();
      end
    end

    mack  = 0;
    mdata = rand_line();
    if (m_phase == M_ACTIVE) begin
      if (m_lat != 0 && m_busy == m_lat) begin
        mack = 1;
        if (!m_we && bmem.exists(m_addr)) mdata = bmem[m_addr];
      end
    end else if (noise_en && $urandom_range(3) == 0) begin
      mack = 1;
    end
    rst_i      = do_rst;
    mem_ack_i  = mack;
    mem_data_i = mdata;

    if (do_rst) model_reset();
    else        model_step(mack, mdata);
  endtask

  task automatic push(input int p, input bit we, input bit [31:0] a,
                      input bit [255:0] d, input int gap);
    req_t r;
    r.we = we; r.addr = a; r.data = d; r.gap = gap;
    q[p].push_back(r);
  endtask

  task automatic clear_tally();
    t_ack[0] = 0; t_ack[1] = 0; t_err[0] = 0; t_err[1] = 0;
    t_en_cycles = 0; t_wr_cycles = 0;
    t_grant_addr.delete();
    t_ack_order.delete();
  endtask

  task automatic do_reset();
    cycle(1);
    cycle(1);
    clear_tally();
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((q[0].size() > 0 || q[1].size() > 0 || drv_en[0] || drv_en[1] ||
            m_phase != M_IDLE) && n < budget) begin
      cycle(0);
      n++;
    end
    check({name, "_completed_in_budget"}, n < budget, 1'b1);
    cycle(0);
    cycle(0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_time_limit: bench did not reach its summary");
    $fatal(1, "time limit");
  end

  initial begin
    int ord;
    int n;
    rst_i = 1; mem_ack_i = 0; mem_data_i = '0;
    for (int p = 0; p < 2; p++) begin
      drv_en[p] = 0; drv_we[p] = 0; drv_addr[p] = '0; drv_data[p] = '0; gap_cnt[p] = 0;
    end
    prev_en  = 0;
    lat_mode = 1;
    noise_en = 1;
    model_reset();
    clear_tally();
    do_reset();
    cycle(0);

    // Reset state
    check("rst_mem_enable", mem_enable_o, 1'b0);
    check("rst_grant0_cnt", grant0_cnt_o, 16'd0);
    check("rst_req0_data",  req0_data_o,  256'd0);
    check("rst_timeout",    timeout_o,    1'b0);

    // Single read with 5-cycle memory latency
    bmem[32'h0] = 256'h5;
    lat_mode = 5;
    push(0, 0, 32'h0, rand_line(), 0);
    drain("t1", 100);
    check("t1_enable_cycles", t_en_cycles, 5);
    check("t1_ack0_count",    t_ack[0],    1);
    check("t1_ack1_count",    t_ack[1],    0);
    check("t1_req0_data",     req0_data_o, 256'h5);
    check("t1_grant0_cnt",    grant0_cnt_o, 16'd1);

    // Simultaneous requests straight after reset: port 0 first
    do_reset();
    bmem[32'h20]  = 256'h111;
    bmem[32'h400] = 256'h222;
    lat_mode = 3;
    push(0, 0, 32'h20,  rand_line(), 0);
    push(1, 0, 32'h400, rand_line(), 0);
    drain("t2", 100);
    check("t2_grants", t_grant_addr.size(), 2);
    if (t_grant_addr.size() == 2) begin
      check("t2_first_addr",  t_grant_addr[0], 32'h20);
      check("t2_second_addr", t_grant_addr[1], 32'h400);
    end
    check("t2_req0_data", req0_data_o, 256'h111);
    check("t2_req1_data", req1_data_o, 256'h222);
    check("t2_ack0_count", t_ack[0], 1);
    check("t2_ack1_count", t_ack[1], 1);

    // Fairness under continuous demand
    do_reset();
    lat_mode = 1;
    for (int i = 0; i < 3; i++) begin
      push(0, 0, 32'h60 + 32'(i), rand_line(), 0);
      push(1, 0, 32'h80 + 32'(i), rand_line(), 0);
    end
    drain("t3", 200);
    ord = 0;
    foreach (t_ack_order[i]) ord = ord * 2 + t_ack_order[i];
    check("t3_ack_count", t_ack_order.size(), 6);
    check("t3_order_010101", ord, 6'b010101);
    check("t3_grant0_cnt", grant0_cnt_o, 16'd3);
    check("t3_grant1_cnt", grant1_cnt_o, 16'd3);

    // Write by port 0, read back by port 1
    do_reset();
    lat_mode = 4;
    push(0, 1, 32'h40, 256'hDEADBEEF, 0);
    drain("t4w", 100);
    check("t4_write_cycles", t_wr_cycles, 4);
    clear_tally();
    push(1, 0, 32'h40, rand_line(), 0);
    drain("t4r", 100);
    check("t4_read_write_cycles", t_wr_cycles, 0);
    check("t4_req1_data", req1_data_o, 256'hDEADBEEF);

    // Watchdog abort, then normal service
    do_reset();
    lat_mode = 0;
    push(1, 0, 32'h80, rand_line(), 0);
    drain("t5a", 100);
    check("t5_enable_cycles", t_en_cycles, TO);
    check("t5_ack1_count",    t_ack[1], 1);
    check("t5_err1_count",    t_err[1], 1);
    check("t5_req1_data",     req1_data_o, 256'd0);
    check("t5_timeout",       timeout_o, 1'b1);
    clear_tally();
    bmem[32'h80] = 256'h77;
    lat_mode = 2;
    push(1, 0, 32'h80, rand_line(), 0);
    drain("t5b", 100);
    check("t5b_err1_count", t_err[1], 0);
    check("t5b_ack1_count", t_ack[1], 1);
    check("t5b_req1_data",  req1_data_o, 256'h77);
    check("t5b_timeout",    timeout_o, 1'b1);

    // Reset three cycles into an access
    do_reset();
    lat_mode = 0;
    push(0, 0, 32'h100, rand_line(), 0);
    n = 0;
    while (!(m_phase == M_ACTIVE && m_busy == 3) && n < 20) begin
      cycle(0);
      n++;
    end
    check("t6_reached_busy", n < 20, 1'b1);
    cycle(1);
    cycle(0);
    check("t6_mem_enable", mem_enable_o, 1'b0);
    check("t6_grant0_cnt", grant0_cnt_o, 16'd0);
    for (int i = 0; i < 4; i++) cycle(0);
    check("t6_no_ack", t_ack[0] + t_ack[1], 0);
    bmem[32'h100] = 256'h99;
    lat_mode = 2;
    push(0, 0, 32'h100, rand_line(), 0);
    drain("t6b", 100);
    check("t6b_req0_data", req0_data_o, 256'h99);
    check("t6b_grant0_cnt", grant0_cnt_o, 16'd1);

    // Random traffic: random latencies (including no ack), spurious acks
    do_reset();
    lat_mode = -1;
    noise_en = 1;
    for (int i = 0; i < 150; i++) begin
      for (int p = 0; p < 2; p++) begin
        push(p, bit'($urandom_range(1)), 32'($urandom_range(7)) * 32'h20,
             rand_line(), int'($urandom_range(3)));
      end
    end
    drain("random", 20000);
    check("random_total_acks", t_ack[0] + t_ack[1], 300);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
